// File: rtl/hamming_chunk_sequencer.sv
// Feeds one N-bit operand pair to a hamming_nbit_ncc accumulator as CC chunks of M bits,
// LSB chunk first, and returns the accumulator's final sum over a valid/ready handshake.
module hamming_chunk_sequencer #(
    parameter int N  = 8,
    parameter int CC = 1,
    parameter int M  = N / CC,
    parameter int RW = $clog2(N),
    parameter int IW = (CC > 1) ? $clog2(CC) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_g,
    input  logic [N-1:0]  in_e,
    output logic [M-1:0]  chunk_g,
    output logic [M-1:0]  chunk_e,
    output logic          acc_rst,
    input  logic [RW-1:0] acc_o,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res,
    output logic          busy
);

    generate
        if (N % CC != 0) begin : g_bad_split
            $error("hamming_chunk_sequencer: N must be a multiple of CC");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

    localparam logic [IW-1:0] IDX_LAST = IW'(CC - 1);

    state_t        state, state_n;
    logic [IW-1:0] idx;
    logic [N-1:0]  g_reg, e_reg;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = CLR;
            CLR:     state_n = RUN;
            RUN:     if (idx == IDX_LAST) state_n = DONE;
            DONE:    if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Chunks are zero outside RUN so the accumulator sum stays put in CLR/DONE/IDLE.
    always_comb begin
        chunk_g = '0;
        chunk_e = '0;
        if (state == RUN) begin
            chunk_g = g_reg[M*int'(idx) +: M];
            chunk_e = e_reg[M*int'(idx) +: M];
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            g_reg     <= '0;
            e_reg     <= '0;
            res       <= '0;
            res_valid <= 1'b0;
            acc_rst   <= 1'b1;
        end else begin
            state   <= state_n;
            // Registered from the next state so the clear pulse covers exactly the CLR cycle.
            acc_rst <= (state_n == CLR);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        g_reg <= in_g;
                        e_reg <= in_e;
                    end
                end
                CLR: idx <= '0;
                RUN: begin
                    if (idx == IDX_LAST) begin
                        res       <= acc_o;
                        res_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: if (res_ready) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_chunk_sequencer.sv
// Bench for hamming_chunk_sequencer: three configurations, each wired to a behavioural
// chunk accumulator, checked against popcount-based expected distances.
module tb_hamming_chunk_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic iv [3];
    logic rr [3];
    logic ir [3];
    logic rv [3];
    logic ar [3];
    logic bz [3];

    logic [7:0]  g0, e0, cg0, ce0;
    logic [2:0]  ao0, r0;
    logic [7:0]  g1, e1;
    logic [3:0]  cg1, ce1;
    logic [2:0]  ao1, r1;
    logic [31:0] g2, e2;
    logic [7:0]  cg2, ce2;
    logic [4:0]  ao2, r2;

    int checks = 0;
    int errors = 0;

    // Accumulator: synchronous clear, adds the popcount of each presented chunk pair,
    // output is the stored sum plus the current chunk's popcount, truncated.
    int osum [3];
    always @(posedge clk) begin
        osum[0] <= ar[0] ? 0 : osum[0] + $countones(cg0 ^ ce0);
        osum[1] <= ar[1] ? 0 : osum[1] + $countones(cg1 ^ ce1);
        osum[2] <= ar[2] ? 0 : osum[2] + $countones(cg2 ^ ce2);
    end
    assign ao0 = 3'(osum[0] + $countones(cg0 ^ ce0));
    assign ao1 = 3'(osum[1] + $countones(cg1 ^ ce1));
    assign ao2 = 5'(osum[2] + $countones(cg2 ^ ce2));

    hamming_chunk_sequencer #(.N(8), .CC(1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_g(g0), .in_e(e0), .chunk_g(cg0), .chunk_e(ce0), .acc_rst(ar[0]),
        .acc_o(ao0), .res_valid(rv[0]), .res_ready(rr[0]), .res(r0), .busy(bz[0])
    );
    hamming_chunk_sequencer #(.N(8), .CC(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_g(g1), .in_e(e1), .chunk_g(cg1), .chunk_e(ce1), .acc_rst(ar[1]),
        .acc_o(ao1), .res_valid(rv[1]), .res_ready(rr[1]), .res(r1), .busy(bz[1])
    );
    hamming_chunk_sequencer #(.N(32), .CC(4)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_g(g2), .in_e(e2), .chunk_g(cg2), .chunk_e(ce2), .acc_rst(ar[2]),
        .acc_o(ao2), .res_valid(rv[2]), .res_ready(rr[2]), .res(r2), .busy(bz[2])
    );

    function automatic int n_of(input int s);
        return (s == 2) ? 32 : 8;
    endfunction

    function automatic int cc_of(input int s);
        return (s == 0) ? 1 : (s == 1) ? 2 : 4;
    endfunction

    function automatic int rw_of(input int s);
        return (s == 2) ? 5 : 3;
    endfunction

    function automatic logic [4:0] get_res(input int s);
        case (s)
            0:       return {2'b00, r0};
            1:       return {2'b00, r1};
            default: return r2;
        endcase
    endfunction

    function automatic logic [15:0] get_chunk(input int s);
        case (s)
            0:       return {cg0, ce0};
            1:       return {4'h0, cg1, 4'h0, ce1};
            default: return {cg2, ce2};
        endcase
    endfunction

    task automatic set_ops(input int s, input logic [31:0] g, input logic [31:0] e);
        case (s)
            0:       begin g0 = g[7:0]; e0 = e[7:0]; end
            1:       begin g1 = g[7:0]; e1 = e[7:0]; end
            default: begin g2 = g;      e2 = e;      end
        endcase
    endtask

    // Distance of the N low bits, reduced modulo 2^RW like the accumulator output.
    function automatic logic [4:0] ref_dist(input int s, input logic [31:0] g, input logic [31:0] e);
        logic [31:0] nmask;
        int d;
        nmask = (n_of(s) == 32) ? 32'hFFFF_FFFF : ((32'd1 << n_of(s)) - 32'd1);
        d = $countones((g ^ e) & nmask);
        return 5'(d % (1 << rw_of(s)));
    endfunction

    function automatic logic [15:0] ref_chunk(input int s, input logic [31:0] g, input logic [31:0] e, input int k);
        int m;
        logic [31:0] mmask;
        m = n_of(s) / cc_of(s);
        mmask = (32'd1 << m) - 32'd1;
        return {8'((g >> (k * m)) & mmask), 8'((e >> (k * m)) & mmask)};
    endfunction

    // One full operation: handshake, clear cycle, chunk sequence, result, optional backpressure.
    task automatic do_op(input int s, input logic [31:0] g, input logic [31:0] e, input int hold);
        int k;
        logic [4:0] want;
        logic [4:0] held;
        k = 0;
        @(negedge clk);
        checks++;
        if (ir[s] !== 1'b1) begin
            errors++; $display("FAIL idle_ready sel=%0d got=%b want=1", s, ir[s]);
        end
        set_ops(s, g, e);
        iv[s] = 1'b1;
        rr[s] = 1'b0;
        @(negedge clk);
        iv[s] = 1'b0;
        checks++;
        if ({ar[s], ir[s], bz[s], get_chunk(s)} !== {3'b101, 16'h0000}) begin
            errors++;
            $display("FAIL clr_phase sel=%0d got acc_rst=%b in_ready=%b busy=%b chunk=%h want 1 0 1 0000",
                     s, ar[s], ir[s], bz[s], get_chunk(s));
        end
        for (int t = 0; t < cc_of(s) + 4 && rv[s] !== 1'b1; t++) begin
            @(negedge clk);
            if (rv[s] !== 1'b1) begin
                checks++;
                if ({ar[s], get_chunk(s)} !== {1'b0, ref_chunk(s, g, e, k)}) begin
                    errors++;
                    $display("FAIL chunk sel=%0d k=%0d got acc_rst=%b chunk=%h want 0 %h",
                             s, k, ar[s], get_chunk(s), ref_chunk(s, g, e, k));
                end
                k++;
            end
        end
        checks++;
        if (k !== cc_of(s)) begin
            errors++; $display("FAIL run_len sel=%0d got=%0d want=%0d", s, k, cc_of(s));
        end
        want = ref_dist(s, g, e);
        checks++;
        if ({rv[s], get_res(s)} !== {1'b1, want}) begin
            errors++;
            $display("FAIL result sel=%0d g=%h e=%h got valid=%b res=%0d want 1 %0d", s, g, e, rv[s], get_res(s), want);
        end
        held = get_res(s);
        repeat (hold) begin
            iv[s] = 1'b1;
            set_ops(s, $urandom, $urandom);
            @(negedge clk);
            checks++;
            if ({rv[s], ir[s], get_res(s), get_chunk(s)} !== {2'b10, held, 16'h0000}) begin
                errors++;
                $display("FAIL hold sel=%0d got valid=%b in_ready=%b res=%0d chunk=%h want 1 0 %0d 0000",
                         s, rv[s], ir[s], get_res(s), get_chunk(s), held);
            end
        end
        iv[s] = 1'b0;
        rr[s] = 1'b1;
        @(negedge clk);
        rr[s] = 1'b0;
        checks++;
        if ({rv[s], ir[s], bz[s]} !== 3'b010) begin
            errors++;
            $display("FAIL release sel=%0d got valid=%b in_ready=%b busy=%b want 0 1 0", s, rv[s], ir[s], bz[s]);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            iv[s] = 1'b0;
            rr[s] = 1'b0;
            set_ops(s, 32'h0, 32'h0);
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({ir[s], ar[s], rv[s], bz[s], get_res(s), get_chunk(s)} !== {4'b1100, 5'd0, 16'h0000}) begin
                errors++;
                $display("FAIL reset_state sel=%0d got rdy=%b acc_rst=%b valid=%b busy=%b res=%0d chunk=%h want 1 1 0 0 0 0000",
                         s, ir[s], ar[s], rv[s], bz[s], get_res(s), get_chunk(s));
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({ar[s], ir[s]} !== 2'b01) begin
                errors++; $display("FAIL idle_after_reset sel=%0d got acc_rst=%b in_ready=%b want 0 1", s, ar[s], ir[s]);
            end
        end
    endtask

    task automatic test_single_cycle;
        do_op(0, 32'hFF, 32'h0F, 0);
    endtask

    task automatic test_chunk_order;
        do_op(2, 32'hFFFF_0000, 32'h0, 0);
    endtask

    task automatic test_backpressure;
        do_op(2, 32'h0000_00F3, 32'h0, 5);
        do_op(0, 32'h81, 32'h7E, 3);
    endtask

    task automatic test_back_to_back;
        do_op(2, 32'hFFFF_FFFF, 32'h0, 0);
        do_op(2, 32'h1, 32'h0, 0);
    endtask

    task automatic test_equal_operands;
        do_op(1, 32'h3C, 32'h3C, 1);
    endtask

    task automatic test_throughput;
        logic [4:0] q[$];
        logic [4:0] want;
        logic [31:0] gc, ec;
        int last;
        bit reload;
        last = -1;
        reload = 1'b0;
        gc = $urandom;
        ec = $urandom;
        @(negedge clk);
        set_ops(2, gc, ec);
        iv[2] = 1'b1;
        rr[2] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clk);
            if (reload) begin
                gc = $urandom;
                ec = $urandom;
                set_ops(2, gc, ec);
                reload = 1'b0;
            end
            if (rv[2] === 1'b1) begin
                want = (q.size() > 0) ? q.pop_front() : 5'h1F;
                checks++;
                if (get_res(2) !== want) begin
                    errors++; $display("FAIL stream_result got=%0d want=%0d", get_res(2), want);
                end
            end
            if (ir[2] === 1'b1 && iv[2] === 1'b1) begin
                q.push_back(ref_dist(2, gc, ec));
                if (last >= 0) begin
                    checks++;
                    if (c - last !== 7) begin
                        errors++; $display("FAIL stream_gap got=%0d want=7", c - last);
                    end
                end
                last = c;
                reload = 1'b1;
            end
        end
        iv[2] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rv[2] === 1'b1) begin
                want = (q.size() > 0) ? q.pop_front() : 5'h1F;
                checks++;
                if (get_res(2) !== want) begin
                    errors++; $display("FAIL drain_result got=%0d want=%0d", get_res(2), want);
                end
            end
        end
        rr[2] = 1'b0;
        checks++;
        if (q.size() !== 0) begin
            errors++; $display("FAIL stream_pending got=%0d want=0", q.size());
        end
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        set_ops(2, 32'h4433_2211, 32'h0);
        iv[2] = 1'b1;
        @(negedge clk);
        iv[2] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bz[2], get_chunk(2)} !== {1'b1, 16'h3300}) begin
            errors++; $display("FAIL mid_run_chunk got busy=%b chunk=%h want 1 3300", bz[2], get_chunk(2));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rv[2], ar[2], ir[2], bz[2], get_chunk(2)} !== {4'b0110, 16'h0000}) begin
            errors++;
            $display("FAIL mid_run_reset got valid=%b acc_rst=%b in_ready=%b busy=%b chunk=%h want 0 1 1 0 0000",
                     rv[2], ar[2], ir[2], bz[2], get_chunk(2));
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 0);
    endtask

    task automatic test_random;
        logic [31:0] g, e;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 8; i++) begin
                g = $urandom;
                e = ($urandom_range(0, 3) == 0) ? g : 32'($urandom);
                do_op(s, g, e, int'($urandom_range(0, 2)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_chunk_order();
        test_backpressure();
        test_back_to_back();
        test_equal_operands();
        test_throughput();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
